// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types: word type plus instruction-cache frame and FSM types.
// Optional icache statistics are enabled with ICACHE_STATS_EN (see icache_direct_mapped).
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam int ICACHE_NSETS = 16;
    localparam int IIDX_W       = $clog2(ICACHE_NSETS);
    // Tag field sized for the smallest legal cache (2 frames); narrower tags are zero-extended.
    localparam int ITAG_W       = WORD_W - 3;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Instruction fetch port (datapath side) and instruction read port (memory side) of the icache.
// slave = cache view, master = view of the surrounding datapath/memory.
interface icache_direct_mapped_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frame_array.sv
// Flop-based frame store: async read by index, one synchronous write port.
// Valid bits clear asynchronously on nRST; tag/data are left unreset.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter  int NSETS = ICACHE_NSETS,
    localparam int IDX_W = $clog2(NSETS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [IDX_W-1:0]  ridx,
    output icache_frame_t     rframe,
    input  logic              wen,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ITAG_W-1:0] wtag,
    input  word_t             wdata
);

    logic [NSETS-1:0]  valid;
    logic [ITAG_W-1:0] tags [NSETS];
    word_t             data [NSETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wen) begin
            valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wen) begin
            tags[widx] <= wtag;
            data[widx] <= wdata;
        end
    end

    assign rframe = {valid[ridx], tags[ridx], data[ridx]};

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only icache: same-cycle hit, one-word fill from memory on miss.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_direct_mapped
    import cpu_types_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS
) (
    input  logic                  CLK,
    input  logic                  nRST,
    icache_direct_mapped_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output word_t                 hit_count,
    output word_t                 miss_count
`endif
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    icache_state_t     state, next_state;
    word_t             miss_addr, next_miss_addr;
    icache_frame_t     rframe;
    logic [IDX_W-1:0]  fetch_idx;
    logic [ITAG_W-1:0] fetch_tag;
    logic              hit;
    logic              wen;
    logic              unused_offset;

    assign fetch_idx     = bus.imemaddr[IDX_W+1:2];
    assign fetch_tag     = ITAG_W'(bus.imemaddr[WORD_W-1:IDX_W+2]);
    assign unused_offset = ^bus.imemaddr[1:0];

    icache_frame_array #(.NSETS(NSETS)) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .ridx   (fetch_idx),
        .rframe (rframe),
        .wen    (wen),
        .widx   (miss_addr[IDX_W+1:2]),
        .wtag   (ITAG_W'(miss_addr[WORD_W-1:IDX_W+2])),
        .wdata  (bus.iload)
    );

    assign hit = bus.imemREN && rframe.valid && (rframe.tag == fetch_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state     <= next_state;
            miss_addr <= next_miss_addr;
        end
    end

    always_comb begin
        next_state     = state;
        next_miss_addr = miss_addr;
        bus.ihit       = 1'b0;
        bus.imemload   = '0;
        bus.iREN       = 1'b0;
        bus.iaddr      = '0;
        wen            = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = rframe.data;
                end else if (bus.imemREN) begin
                    next_miss_addr = {bus.imemaddr[WORD_W-1:2], 2'b00};
                    next_state     = FILL;
                end
            end
            // The fill is committed to miss_addr; the live fetch address is ignored here.
            FILL: begin
                bus.iREN  = 1'b1;
                bus.iaddr = miss_addr;
                if (!bus.iwait) begin
                    wen        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.ihit && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if ((state == IDLE) && (next_state == FILL) && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: miss/fill timing, hits, conflicts, mid-fill changes, reset.
// Statistics checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_direct_mapped;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    icache_direct_mapped_if bus();

`ifdef ICACHE_STATS_EN
    word_t hit_count, miss_count;
    word_t h0;
`endif

    icache_direct_mapped #(.NSETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Called in IDLE just after an edge: miss detect cycle, then lat wait cycles and one completion cycle.
    // Returns just after the edge that writes the frame.
    task automatic miss_fill(input string tag, input word_t addr, input word_t exp_iaddr,
                             input int lat, input word_t data);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        #2;
        check({tag, "_detect_ihit"}, 32'(bus.ihit), 32'd0);
        check({tag, "_detect_iREN"}, 32'(bus.iREN), 32'd0);
        for (int k = 0; k <= lat; k++) begin
            next_cycle();
            bus.iwait = (k < lat);
            bus.iload = (k < lat) ? 32'hDEAD_BEEF : data;
            #2;
            check({tag, "_fill_iREN"}, 32'(bus.iREN), 32'd1);
            check({tag, "_fill_iaddr"}, bus.iaddr, exp_iaddr);
            check({tag, "_fill_ihit"}, 32'(bus.ihit), 32'd0);
        end
        next_cycle();
        bus.iwait = 1'b1;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.imemREN  = 1'b1;
        bus.imemaddr = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        #3;
        check("rst_ihit", 32'(bus.ihit), 32'd0);
        check("rst_iREN", 32'(bus.iREN), 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_imemload", bus.imemload, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        bus.imemREN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();

        // Cold miss on 0x0 with three wait cycles.
        miss_fill("t1", 32'h0, 32'h0, 3, 32'h0000_0093);
        #2;
        check("t1_hit", 32'(bus.ihit), 32'd1);
        check("t1_imemload", bus.imemload, 32'h0000_0093);
        check("t1_iREN_idle", 32'(bus.iREN), 32'd0);
        check("t1_iaddr_idle", bus.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        check("t1_miss_count", miss_count, 32'd1);
`endif

        // Back-to-back hits.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
`ifdef ICACHE_STATS_EN
            if (k == 0) h0 = hit_count;
`endif
            #2;
            check("t2_hit", 32'(bus.ihit), 32'd1);
            check("t2_imemload", bus.imemload, 32'h0000_0093);
            check("t2_iREN", 32'(bus.iREN), 32'd0);
        end
        next_cycle();
`ifdef ICACHE_STATS_EN
        check("t2_hit_count_delta", hit_count - h0, 32'd4);
`endif

        // Conflict: 0x40 maps to idx 0 with tag 1 and evicts 0x0.
        miss_fill("t3a", 32'h40, 32'h40, 1, 32'hAAAA_0040);
        #2;
        check("t3a_hit", 32'(bus.ihit), 32'd1);
        check("t3a_imemload", bus.imemload, 32'hAAAA_0040);
        next_cycle();
        miss_fill("t3b", 32'h0, 32'h0, 0, 32'h0000_0093);
        #2;
        check("t3b_hit", 32'(bus.ihit), 32'd1);
        check("t3b_imemload", bus.imemload, 32'h0000_0093);

        // Address changes from 0x8 to 0xC while the 0x8 fill is outstanding.
        next_cycle();
        bus.imemaddr = 32'h8;
        #2;
        check("t4_detect_ihit", 32'(bus.ihit), 32'd0);
        next_cycle();
        bus.imemaddr = 32'hC;
        bus.iwait    = 1'b1;
        #2;
        check("t4_fill_iREN", 32'(bus.iREN), 32'd1);
        check("t4_fill_iaddr", bus.iaddr, 32'h8);
        next_cycle();
        bus.iwait = 1'b0;
        bus.iload = 32'hD000_D008;
        #2;
        check("t4_done_iaddr", bus.iaddr, 32'h8);
        next_cycle();
        bus.iwait = 1'b1;
        #2;
        check("t4_c_miss_ihit", 32'(bus.ihit), 32'd0);
        check("t4_c_miss_iREN", 32'(bus.iREN), 32'd0);
        next_cycle();
        #2;
        check("t4_c_fill_iREN", 32'(bus.iREN), 32'd1);
        check("t4_c_fill_iaddr", bus.iaddr, 32'hC);
        bus.iwait = 1'b0;
        bus.iload = 32'hD000_D00C;
        next_cycle();
        bus.iwait = 1'b1;
        #2;
        check("t4_c_hit", 32'(bus.ihit), 32'd1);
        check("t4_c_imemload", bus.imemload, 32'hD000_D00C);
        bus.imemaddr = 32'h8;
        #1;
        check("t4_8_hit", 32'(bus.ihit), 32'd1);
        check("t4_8_imemload", bus.imemload, 32'hD000_D008);

        // Reset in the middle of a fill of 0x10.
        next_cycle();
        bus.imemaddr = 32'h10;
        #2;
        check("t5_detect_ihit", 32'(bus.ihit), 32'd0);
        next_cycle();
        #2;
        check("t5_fill_iREN", 32'(bus.iREN), 32'd1);
        check("t5_fill_iaddr", bus.iaddr, 32'h10);
        nRST = 1'b0;
        #1;
        check("t5_rst_iREN", 32'(bus.iREN), 32'd0);
        check("t5_rst_iaddr", bus.iaddr, 32'd0);
        bus.imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();
        miss_fill("t5b", 32'h0, 32'h0, 0, 32'h0000_0093);
        #2;
        check("t5b_hit", 32'(bus.ihit), 32'd1);

        // Byte offset is ignored: 0x6 fetches word 0x4.
        next_cycle();
        miss_fill("t6", 32'h6, 32'h4, 2, 32'h0000_0404);
        #2;
        check("t6_hit", 32'(bus.ihit), 32'd1);
        check("t6_imemload", bus.imemload, 32'h0000_0404);
        bus.imemaddr = 32'h4;
        #1;
        check("t6_aligned_hit", 32'(bus.ihit), 32'd1);
        next_cycle();
`ifdef ICACHE_STATS_EN
        check("t6_miss_count", miss_count, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the single-cycle datapath instruction port and the memory controller instruction port.
- Serves fetches from the datapath (imemREN, imemaddr) with a same-cycle hit response.
- On a miss, fetches one word from memory, fills the frame, then serves the fetch.
- Read-only: no write path, no dirty state.

Parameters:
- NSETS, 16, number of one-word frames; power of two, min 2; index width IDX_W = log2(NSETS).
- WORD_W, 32, instruction/address width; fixed by the codebase word type.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  fetch served this cycle; datapath PC advances on this.
- imemload  output  32  instruction word; valid only when ihit=1.
- iREN  output  1  memory read request.
- iaddr  output  32  memory read word address, bits [1:0]=0.
- iwait  input  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  input  32  memory read data.

Behaviour:
- Address split: offset [1:0], index [IDX_W+1:2], tag [31:IDX_W+2].
- Frame: valid bit, tag, 32-bit data. Storage is flops, so no SRAM timing.
- Reset (async, nRST=0): all valid bits=0, state=IDLE, ihit=0, iREN=0, iaddr=0, imemload=0. Tag and data are don't-care.
- FSM, 2 states.
- IDLE:
  - Hit = imemREN & valid[idx] & tag match.
  - On hit: ihit=1 and imemload=data[idx] combinationally, 0-cycle latency.
  - On miss with imemREN=1: latch the word-aligned imemaddr into miss_addr; next state=FILL; ihit=0.
  - imemREN=0: ihit=0, no state change.
- FILL:
  - iREN=1, iaddr=miss_addr, ihit=0.
  - While iwait=1: hold.
  - When iwait=0: write valid=1, tag and data=iload into frame miss_addr index; next state=IDLE.
  - The fetch then hits on the following cycle, provided the address is unchanged.
- Miss penalty: 1 (IDLE detect) + memory latency + 1 (hit cycle).
- imemload never bypasses iload directly; data is always sourced from the frame array.
- FILL completes for the latched miss_addr even if imemREN drops or imemaddr changes mid-fill. The new address is evaluated in IDLE afterwards.
- Conflict: a fill to the same index overwrites the previous tag unconditionally.
- Reset asserted mid-FILL: returns to IDLE immediately and drops iREN. The partially serviced fetch is lost and all frames are invalid.
- Outside FILL: iREN=0 and iaddr=0.
- No flush input. The datapath halt does not affect the cache.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds output ports hit_count [31:0] and miss_count [31:0], both reset to 0.
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE->FILL transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gains the following; no new package:
  - ICACHE_NSETS default, ITAG_W and IIDX_W constants.
  - icache_frame_t packed struct {valid, tag, data}.
  - icache_state_t enum {IDLE, FILL}.
- One sub-module, icache_frame_array:
  - NSETS frames with async read by index.
  - Single synchronous write port (wen, widx, wtag, wdata).
  - Async clear of all valid bits on nRST.
- FSM and hit compare live in the top module.

Test Plan:
- Reset then imemREN=1, imemaddr=0x0000_0000; memory returns 0x0000_0093 after 3 iwait cycles -> ihit=0 for 5 cycles, iREN=1 with iaddr=0x0 for 4 cycles, then ihit=1, imemload=0x0000_0093; miss_count=1.
- Repeat fetch of 0x0 for 4 cycles -> ihit=1 every cycle, iREN=0; hit_count increments by 4.
- NSETS=16: fill 0x0040 (idx 0, tag 1) after 0x0000 -> second fetch of 0x0000 misses again (conflict eviction), iaddr=0x0000.
- Mid-FILL of 0x0008, switch imemaddr to 0x000C -> fill completes into idx 2 with tag 0. Next IDLE cycle misses on 0x000C and iaddr=0x000C.
- Assert nRST low during FILL -> iREN=0 same cycle. After release, a fetch of the previously filled 0x0000 misses.
- Fetch imemaddr=0x0000_0006 -> treated as 0x0000_0004; iaddr=0x0000_0004.
